// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared encodings and defaults for the branch predictor
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int BP_ENTRIES_DEFAULT = 64;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bp_state_t;

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup / BRU update / prediction bundle
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic            bp_lookup_valid_in;
    logic [XLEN-1:0] bp_lookup_pc_in;
    logic            bp_stall_in;
    logic            bp_update_en_in;
    logic            bp_update_result_in;
    logic [XLEN-1:0] bp_update_pc_in;
    logic            bp_prediction_out;
    logic            bp_prediction_valid_out;
    logic            bp_ready_out;

    modport master (
        output bp_lookup_valid_in,
        output bp_lookup_pc_in,
        output bp_stall_in,
        output bp_update_en_in,
        output bp_update_result_in,
        output bp_update_pc_in,
        input  bp_prediction_out,
        input  bp_prediction_valid_out,
        input  bp_ready_out
    );

    modport slave (
        input  bp_lookup_valid_in,
        input  bp_lookup_pc_in,
        input  bp_stall_in,
        input  bp_update_en_in,
        input  bp_update_result_in,
        input  bp_update_pc_in,
        output bp_prediction_out,
        output bp_prediction_valid_out,
        output bp_ready_out
    );
endinterface

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - combinational 2-bit saturating counter step
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       taken_in,
    output logic [1:0] cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (taken_in) begin
            if (cnt_in != ST) cnt_out = cnt_in + 2'd1;
        end else begin
            if (cnt_in != SNT) cnt_out = cnt_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - PC-indexed 2-bit BHT predictor; BRANCH_PREDICTOR_GSHARE_EN adds gshare indexing
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = BP_ENTRIES_DEFAULT
) (
    input  logic               clock_in,
    input  logic               reset_in,
    branch_predictor_if.slave  bp
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       bht [ENTRIES];
    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] init_idx_q;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [1:0]       up_cnt, up_cnt_next;
    logic             running, bypass_hit, lookup_pred;
    logic             pred_q, pred_valid_q;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;

    // Update index uses the history as it stood before this update shifts in
    assign lk_idx = bp.bp_lookup_pc_in[IDX_W+1:2] ^ ghr_q;
    assign up_idx = bp.bp_update_pc_in[IDX_W+1:2] ^ ghr_q;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            ghr_q <= '0;
        end else if (running && bp.bp_update_en_in) begin
            ghr_q <= {ghr_q[IDX_W-2:0], bp.bp_update_result_in};
        end
    end
`else
    assign lk_idx = bp.bp_lookup_pc_in[IDX_W+1:2];
    assign up_idx = bp.bp_update_pc_in[IDX_W+1:2];
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.bp_lookup_pc_in[XLEN-1:IDX_W+2], bp.bp_lookup_pc_in[1:0],
                              bp.bp_update_pc_in[XLEN-1:IDX_W+2], bp.bp_update_pc_in[1:0]};

    assign running = (state_q == RUN);
    assign up_cnt  = bht[up_idx];

    sat_counter2 u_sat (
        .cnt_in   (up_cnt),
        .taken_in (bp.bp_update_result_in),
        .cnt_out  (up_cnt_next)
    );

    // A lookup racing an update to the same entry sees the trained counter
    assign bypass_hit  = bp.bp_update_en_in && (lk_idx == up_idx);
    assign lookup_pred = bypass_hit ? up_cnt_next[1] : bht[lk_idx][1];

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            init_idx_q <= '0;
        end else if (state_q == INIT) begin
            init_idx_q <= init_idx_q + 1'b1;
        end
    end

    // Table has no reset; INIT sweeps every entry to weakly not-taken
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            if (state_q == INIT) begin
                bht[init_idx_q] <= WNT;
            end else if (bp.bp_update_en_in) begin
                bht[up_idx] <= up_cnt_next;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in || !running) begin
            pred_q       <= 1'b0;
            pred_valid_q <= 1'b0;
        end else if (!bp.bp_stall_in) begin
            if (bp.bp_lookup_valid_in) begin
                pred_q       <= lookup_pred;
                pred_valid_q <= 1'b1;
            end else begin
                pred_q       <= 1'b0;
                pred_valid_q <= 1'b0;
            end
        end
    end

    assign bp.bp_prediction_out       = pred_q;
    assign bp.bp_prediction_valid_out = pred_valid_q;
    assign bp.bp_ready_out            = running;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(32)) bp_if ();

    branch_predictor #(.XLEN(32), .ENTRIES(64)) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bp       (bp_if)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] m_tbl [64];
    logic [5:0] m_ghr;
    int         m_cnt;
    logic       m_pv, m_pred;
    logic [2:0] sb [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] m_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [5:0] m_idx(input logic [31:0] pc);
        logic [5:0] i;
        i = pc[7:2];
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        i = i ^ m_ghr;
`endif
        return i;
    endfunction

    task automatic step(input logic r, input logic lv, input logic [31:0] lpc, input logic stl,
                        input logic ue, input logic ur, input logic [31:0] upc);
        logic [5:0] li, ui;
        logic [1:0] nc;
        logic [2:0] exp;
        rst = r;
        bp_if.bp_lookup_valid_in  = lv;
        bp_if.bp_lookup_pc_in     = lpc;
        bp_if.bp_stall_in         = stl;
        bp_if.bp_update_en_in     = ue;
        bp_if.bp_update_result_in = ur;
        bp_if.bp_update_pc_in     = upc;
        if (r) begin
            m_pv = 0; m_pred = 0; m_cnt = 0; m_ghr = '0;
            for (int i = 0; i < 64; i++) m_tbl[i] = 2'b01;
        end else if (m_cnt < 64) begin
            m_pv = 0; m_pred = 0; m_cnt++;
        end else begin
            li = m_idx(lpc);
            ui = m_idx(upc);
            nc = m_sat(m_tbl[ui], ur);
            if (!stl) begin
                if (lv) begin
                    m_pred = (ue && ui == li) ? nc[1] : m_tbl[li][1];
                    m_pv = 1;
                end else begin
                    m_pred = 0; m_pv = 0;
                end
            end
            if (ue) begin
                m_tbl[ui] = nc;
                m_ghr = {m_ghr[4:0], ur};
            end
        end
        sb.push_back({m_cnt == 64, m_pv, m_pred});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check_eq("ready", 32'(bp_if.bp_ready_out), 32'(exp[2]));
        check_eq("valid", 32'(bp_if.bp_prediction_valid_out), 32'(exp[1]));
        check_eq("pred", 32'(bp_if.bp_prediction_out), 32'(exp[0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic ur, input logic [31:0] pc);
        step(0, 0, 0, 0, 1, ur, pc);
    endtask

    task automatic look(input logic [31:0] pc);
        step(0, 1, pc, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] pcs [5];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h108; pcs[4] = 32'h3fc;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_eq("rst_ready", 32'(bp_if.bp_ready_out), 0);
        check_eq("rst_valid", 32'(bp_if.bp_prediction_valid_out), 0);

        idle(10);
        step(0, 1, 32'h104, 0, 1, 1, 32'h104);
        check_eq("init_lookup_valid", 32'(bp_if.bp_prediction_valid_out), 0);
        idle(52);
        check_eq("ready_edge63", 32'(bp_if.bp_ready_out), 0);
        idle(1);
        check_eq("ready_edge64", 32'(bp_if.bp_ready_out), 1);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        look(32'h104);
        check_eq("post_init_pred", 32'(bp_if.bp_prediction_out), 0);
        check_eq("post_init_valid", 32'(bp_if.bp_prediction_valid_out), 1);

        upd(1, 32'h100); upd(1, 32'h100);
        look(32'h100);
        check_eq("train_st", 32'(bp_if.bp_prediction_out), 1);
        upd(1, 32'h100); upd(0, 32'h100); upd(0, 32'h100);
        look(32'h100);
        check_eq("train_back_wnt", 32'(bp_if.bp_prediction_out), 0);

        upd(1, 32'h100); upd(1, 32'h100);
        look(32'h200);
        check_eq("alias_idx0", 32'(bp_if.bp_prediction_out), 1);
        look(32'h104);
        check_eq("alias_idx1", 32'(bp_if.bp_prediction_out), 0);

        upd(0, 32'h100); upd(0, 32'h100);
        step(0, 1, 32'h100, 0, 1, 1, 32'h100);
        check_eq("bypass", 32'(bp_if.bp_prediction_out), 1);

        upd(1, 32'h100);
        look(32'h100);
        step(0, 1, 32'h104, 1, 0, 0, 0);
        step(0, 1, 32'h104, 1, 1, 0, 32'h100);
        step(0, 1, 32'h104, 1, 0, 0, 0);
        check_eq("stall_hold_pred", 32'(bp_if.bp_prediction_out), 1);
        check_eq("stall_hold_valid", 32'(bp_if.bp_prediction_valid_out), 1);
        look(32'h100);
        check_eq("stall_update_wt", 32'(bp_if.bp_prediction_out), 1);
        upd(0, 32'h100);
        look(32'h100);
        check_eq("wt_to_wnt", 32'(bp_if.bp_prediction_out), 0);

        step(0, 1, 32'h108, 0, 1, 1, 32'h104);
        check_eq("diff_idx", 32'(bp_if.bp_prediction_out), 0);
        idle(1);
        check_eq("idle_clears", 32'(bp_if.bp_prediction_valid_out), 0);

        upd(1, 32'h100); upd(1, 32'h100); upd(1, 32'h100);
        step(1, 1, 32'h100, 0, 0, 0, 0);
        check_eq("midrun_rst_pred", 32'(bp_if.bp_prediction_out), 0);
        check_eq("midrun_rst_ready", 32'(bp_if.bp_ready_out), 0);
        idle(64);
        look(32'h100);
        check_eq("reinit_pred", 32'(bp_if.bp_prediction_out), 0);
`else
        upd(1, 32'h100); upd(1, 32'h100); upd(0, 32'h100);
        check_eq("ghr_110", 32'(dut.ghr_q), 32'h6);
        look(32'h100);
        check_eq("gshare_idx6", 32'(bp_if.bp_prediction_out), 0);
`endif

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), pcs[$urandom_range(0, 4)],
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 pcs[$urandom_range(0, 4)]);
        end
        idle(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
